pix_csc: RTL
============

PIX_CSC -- requirements
Module: pix_csc

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning per-channel pixel width, legal range 8..12.
REQ-002 SHALL have parameter VS_POL, default 1, meaning in_vsync active level (1 = active-high).
REQ-003 SHALL have port clk, input, 1, pixel clock; the only clock.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ce, input, 1, clock enable; low stalls the whole block.
REQ-006 SHALL have port mode, input, 2, requested conversion mode.
REQ-007 SHALL have ports R, G, B, input, DATA_W each, input pixel channels.
REQ-008 SHALL have ports in_hsync, in_vsync, in_de, input, 1 each, input timing.
REQ-009 SHALL have ports C0, C1, C2, output, DATA_W each, converted channels.
REQ-010 SHALL have ports out_hsync, out_vsync, out_de, output, 1 each, delayed timing.
REQ-011 SHALL have port mode_active, output, 2, mode currently applied to pixels.

Function
REQ-012 Mode encoding SHALL be: 0 PASS (C0..C2 = R,G,B), 1 GRAY (C0=C1=C2=Y), 2 YCBCR (C0=Y, C1=Cb, C2=Cr), 3 INV (C0..C2 = max-R, max-G, max-B), with max = 2^DATA_W-1.
REQ-013 Y SHALL equal (77R + 150G + 29B + 128) >> 8, computed without overflow.
REQ-014 Cb SHALL equal ((-43R - 85G + 128B + 128) >>> 8) + 2^(DATA_W-1), with >>> an arithmetic (floor) shift.
REQ-015 Cr SHALL equal ((128R - 107G - 21B + 128) >>> 8) + 2^(DATA_W-1).
REQ-016 Y, Cb and Cr SHALL each be saturated to [0, max] before output.
REQ-017 Latency SHALL be exactly 4 ce-qualified cycles in every mode, from input sample to output.
REQ-018 out_hsync, out_vsync and out_de SHALL be the inputs delayed by the same 4 ce-qualified cycles, bit-exact.
REQ-019 C0..C2 SHALL be driven 0 whenever out_de is 0.
REQ-020 When ce=0, all pipeline registers and mode_active SHALL hold, and outputs SHALL stay constant.
REQ-021 A vsync start SHALL be an edge where ce=1, in_vsync=VS_POL, and the registered previous in_vsync != VS_POL.
REQ-022 At a vsync-start edge, mode_active SHALL load mode.
REQ-023 The pixel sampled at a vsync-start edge SHALL use the old mode; pixels from the next ce-cycle onward SHALL use the new mode.
REQ-024 mode changes outside a vsync start SHALL have no effect, so the mode is never switched mid-frame.
REQ-025 The mode SHALL be carried down the pipeline with each pixel, so pixels already in flight finish in the mode they entered with.

Reset
REQ-026 rst_n low SHALL asynchronously clear all pipeline data and timing registers to 0.
REQ-027 rst_n low SHALL clear the previous-vsync register to !VS_POL.
REQ-028 rst_n low SHALL set mode_active to 0 (PASS).
REQ-029 After reset deassertion, outputs SHALL be 0 until valid data has traversed the 4-cycle pipeline.
REQ-030 Reset asserted mid-frame SHALL discard in-flight pixels; no partial pixel shall emerge after release.

Structure
REQ-031 Package pix_csc_pkg SHALL hold: mode encodings, the nine coefficients, rounding constant 128, and latency constant 4.
REQ-032 The timing delay SHALL be the sub-module pix_delay_line, parametrised by WIDTH and DEPTH, with ce and rst_n.
REQ-033 pix_delay_line SHALL be instantiated for {hsync, vsync, de} (WIDTH 3, DEPTH 4).

Verification
REQ-034 Reset release, mode=0, DATA_W=8, input (10,20,30) with de=1 -> C=(10,20,30) with out_de=1 exactly 4 cycles later; outputs 0 before that.
REQ-035 mode=2 applied at vsync start, input red (255,0,0) -> C0=77, C1=85, C2=255 (Cr saturated).
REQ-036 mode=2, input white (255,255,255) -> (255,128,128); input blue (0,0,255) -> C1=255 (saturated).
REQ-037 Change mode from 0 to 3 mid-frame -> mode_active and outputs stay PASS until the next vsync start, then INV: (10,20,30) -> (245,235,225).
REQ-038 Drop ce for 5 cycles mid-line -> outputs and out_* frozen, then the pixel sequence resumes with no loss or duplication and total latency of 4 ce-cycles.
REQ-039 Assert rst_n mid-line with de=1 -> all outputs 0 immediately and mode_active=0; after release the first nonzero out_de appears 4 cycles after the first new in_de.

Source files
------------

// File: rtl/pix_csc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pix_csc_pkg
// Purpose  : Mode encodings and fixed-point constants for the colour converter
// Revision : 1.0
// ============================================================================
package pix_csc_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_GRAY  = 2'd1,
        MODE_YCBCR = 2'd2,
        MODE_INV   = 2'd3
    } csc_mode_e;

    // 8-bit fractional coefficients (scaled by 256)
    localparam int c_y_r  = 77;
    localparam int c_y_g  = 150;
    localparam int c_y_b  = 29;
    localparam int c_cb_r = -43;
    localparam int c_cb_g = -85;
    localparam int c_cb_b = 128;
    localparam int c_cr_r = 128;
    localparam int c_cr_g = -107;
    localparam int c_cr_b = -21;

    localparam int c_round   = 128;
    localparam int c_latency = 4;

endpackage
`default_nettype wire

// File: rtl/pix_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : pix_delay_line
// Purpose  : Clock-enabled shift register delaying a WIDTH-bit bus by DEPTH cycles
// Revision : 1.0
// ============================================================================
module pix_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else if (ce) begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/pix_csc.sv
`default_nettype none
// ============================================================================
// Module   : pix_csc
// Purpose  : 4-stage RGB converter (pass/gray/YCbCr/invert), mode switched at vsync
// Revision : 1.0
// ============================================================================
module pix_csc
    import pix_csc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter bit VS_POL = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] R,
    input  logic [DATA_W-1:0] G,
    input  logic [DATA_W-1:0] B,
    input  logic              in_hsync,
    input  logic              in_vsync,
    input  logic              in_de,
    output logic [DATA_W-1:0] C0,
    output logic [DATA_W-1:0] C1,
    output logic [DATA_W-1:0] C2,
    output logic              out_hsync,
    output logic              out_vsync,
    output logic              out_de,
    output logic [1:0]        mode_active
);

    // Two guard bits above the largest signed sum magnitude
    localparam int SW = DATA_W + 10;

    localparam logic [DATA_W-1:0]    c_max   = DATA_W'((2 ** DATA_W) - 1);
    localparam logic signed [SW-1:0] c_max_s = SW'((2 ** DATA_W) - 1);
    localparam logic signed [SW-1:0] c_half  = SW'(2 ** (DATA_W - 1));
    localparam logic signed [SW-1:0] c_rnd   = SW'(c_round);
    localparam logic signed [SW-1:0] c_k_yr  = SW'(c_y_r);
    localparam logic signed [SW-1:0] c_k_yg  = SW'(c_y_g);
    localparam logic signed [SW-1:0] c_k_yb  = SW'(c_y_b);
    localparam logic signed [SW-1:0] c_k_cbr = SW'(c_cb_r);
    localparam logic signed [SW-1:0] c_k_cbg = SW'(c_cb_g);
    localparam logic signed [SW-1:0] c_k_cbb = SW'(c_cb_b);
    localparam logic signed [SW-1:0] c_k_crr = SW'(c_cr_r);
    localparam logic signed [SW-1:0] c_k_crg = SW'(c_cr_g);
    localparam logic signed [SW-1:0] c_k_crb = SW'(c_cr_b);

    function automatic logic signed [SW-1:0] ext(input logic [DATA_W-1:0] v);
        return $signed({{(SW-DATA_W){1'b0}}, v});
    endfunction

    function automatic logic [DATA_W-1:0] sat(input logic signed [SW-1:0] v);
        if (v < 0)
            return '0;
        else if (v > c_max_s)
            return c_max;
        else
            return v[DATA_W-1:0];
    endfunction

    logic                     r_vs_prev;
    csc_mode_e                r_mode_active;
    logic                     w_vs_start;
    logic [DATA_W-1:0]        r_s1_r, r_s1_g, r_s1_b;
    csc_mode_e                r_s1_mode;
    logic signed [SW-1:0]     w_y_sum, w_cb_sum, w_cr_sum;
    logic signed [SW-1:0]     r_s2_y, r_s2_cb, r_s2_cr;
    logic [DATA_W-1:0]        r_s2_r, r_s2_g, r_s2_b;
    csc_mode_e                r_s2_mode;
    logic [DATA_W-1:0]        r_s3_y, r_s3_cb, r_s3_cr;
    logic [DATA_W-1:0]        r_s3_r, r_s3_g, r_s3_b;
    csc_mode_e                r_s3_mode;
    logic [DATA_W-1:0]        w_c0, w_c1, w_c2;
    logic [DATA_W-1:0]        r_s4_c0, r_s4_c1, r_s4_c2;
    logic [2:0]               w_timing;

    assign w_vs_start = (in_vsync == VS_POL) && (r_vs_prev != VS_POL);

    assign w_y_sum  = c_k_yr  * ext(r_s1_r) + c_k_yg  * ext(r_s1_g) + c_k_yb  * ext(r_s1_b) + c_rnd;
    assign w_cb_sum = c_k_cbr * ext(r_s1_r) + c_k_cbg * ext(r_s1_g) + c_k_cbb * ext(r_s1_b) + c_rnd;
    assign w_cr_sum = c_k_crr * ext(r_s1_r) + c_k_crg * ext(r_s1_g) + c_k_crb * ext(r_s1_b) + c_rnd;

    always_comb begin
        w_c0 = r_s3_r;
        w_c1 = r_s3_g;
        w_c2 = r_s3_b;
        case (r_s3_mode)
            MODE_GRAY:  begin w_c0 = r_s3_y; w_c1 = r_s3_y;  w_c2 = r_s3_y;  end
            MODE_YCBCR: begin w_c0 = r_s3_y; w_c1 = r_s3_cb; w_c2 = r_s3_cr; end
            MODE_INV:   begin
                w_c0 = c_max - r_s3_r;
                w_c1 = c_max - r_s3_g;
                w_c2 = c_max - r_s3_b;
            end
            default: ;
        endcase
    end

    // The pixel sampled on the vsync-start edge captures the mode before it updates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_prev     <= !VS_POL;
            r_mode_active <= MODE_PASS;
            r_s1_r        <= '0;
            r_s1_g        <= '0;
            r_s1_b        <= '0;
            r_s1_mode     <= MODE_PASS;
            r_s2_y        <= '0;
            r_s2_cb       <= '0;
            r_s2_cr       <= '0;
            r_s2_r        <= '0;
            r_s2_g        <= '0;
            r_s2_b        <= '0;
            r_s2_mode     <= MODE_PASS;
        end else if (ce) begin
            r_vs_prev <= in_vsync;
            if (w_vs_start)
                r_mode_active <= csc_mode_e'(mode);
            r_s1_r    <= R;
            r_s1_g    <= G;
            r_s1_b    <= B;
            r_s1_mode <= r_mode_active;
            r_s2_y    <= w_y_sum;
            r_s2_cb   <= w_cb_sum;
            r_s2_cr   <= w_cr_sum;
            r_s2_r    <= r_s1_r;
            r_s2_g    <= r_s1_g;
            r_s2_b    <= r_s1_b;
            r_s2_mode <= r_s1_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3_y    <= '0;
            r_s3_cb   <= '0;
            r_s3_cr   <= '0;
            r_s3_r    <= '0;
            r_s3_g    <= '0;
            r_s3_b    <= '0;
            r_s3_mode <= MODE_PASS;
            r_s4_c0   <= '0;
            r_s4_c1   <= '0;
            r_s4_c2   <= '0;
        end else if (ce) begin
            r_s3_y    <= sat(r_s2_y >>> 8);
            r_s3_cb   <= sat((r_s2_cb >>> 8) + c_half);
            r_s3_cr   <= sat((r_s2_cr >>> 8) + c_half);
            r_s3_r    <= r_s2_r;
            r_s3_g    <= r_s2_g;
            r_s3_b    <= r_s2_b;
            r_s3_mode <= r_s2_mode;
            r_s4_c0   <= w_c0;
            r_s4_c1   <= w_c1;
            r_s4_c2   <= w_c2;
        end
    end

    pix_delay_line #(
        .WIDTH (3),
        .DEPTH (c_latency)
    ) u_timing (
        .clk    (clk),
        .rst_n  (rst_n),
        .ce     (ce),
        .i_data ({in_hsync, in_vsync, in_de}),
        .o_data (w_timing)
    );

    assign out_hsync   = w_timing[2];
    assign out_vsync   = w_timing[1];
    assign out_de      = w_timing[0];
    assign C0          = out_de ? r_s4_c0 : '0;
    assign C1          = out_de ? r_s4_c1 : '0;
    assign C2          = out_de ? r_s4_c2 : '0;
    assign mode_active = r_mode_active;

endmodule
`default_nettype wire
